// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: port widths, owner tags, FSM states.
package dmem_arbiter_pkg;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = 4;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef enum logic {
    ST_ARB       = 1'b0,
    ST_FORCE_DBG = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic   vld;
    owner_e owner;
  } rsp_tag_t;

  typedef struct packed {
    logic          we;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  // Reads never drive byte enables, so the RAM sees a pure read.
  function automatic logic [SW-1:0] byte_we(input logic we, input logic [SW-1:0] sel);
    return we ? sel : '0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// LSU, debug and RAM-side signals of the data-RAM arbiter.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic          lsu_req_en;
  logic          lsu_req_we;
  logic [SW-1:0] lsu_req_sel;
  logic [AW-1:0] lsu_req_addr;
  logic [DW-1:0] lsu_req_wdata;
  logic          lsu_stallreq;
  logic          lsu_rvalid;
  logic [DW-1:0] lsu_rdata;

  logic          dbg_req_valid;
  logic          dbg_req_we;
  logic [SW-1:0] dbg_req_sel;
  logic [AW-1:0] dbg_req_addr;
  logic [DW-1:0] dbg_req_wdata;
  logic          dbg_req_ready;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          ram_en;
  logic [SW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  lsu_req_en, lsu_req_we, lsu_req_sel, lsu_req_addr, lsu_req_wdata,
    input  dbg_req_valid, dbg_req_we, dbg_req_sel, dbg_req_addr, dbg_req_wdata,
    input  ram_rdata,
    output lsu_stallreq, lsu_rvalid, lsu_rdata,
    output dbg_req_ready, dbg_rvalid, dbg_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output lsu_req_en, lsu_req_we, lsu_req_sel, lsu_req_addr, lsu_req_wdata,
    output dbg_req_valid, dbg_req_we, dbg_req_sel, dbg_req_addr, dbg_req_wdata,
    output ram_rdata,
    input  lsu_stallreq, lsu_rvalid, lsu_rdata,
    input  dbg_req_ready, dbg_rvalid, dbg_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/dmem_arbiter_rsp_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift register tracking reads in flight to the RAM.
module rsp_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t in_tag,
  output rsp_tag_t out_tag
);

  rsp_tag_t [RD_LAT-1:0] tag_pipe;

  // Reset clears every stage so in-flight reads never produce a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign out_tag = tag_pipe[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-RAM port between the LSU and a debug/DMA requester,
// with bounded debug starvation and owner-tagged read returns.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input logic          clk,
  input logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  arb_state_e    state;
  logic [CW-1:0] burst_cnt;
  logic          lsu_gnt, dbg_gnt, any_gnt;
  mem_req_t      lsu_req, dbg_req, gnt_req;
  rsp_tag_t      tag_in, tag_out;
  logic          lsu_hit, dbg_hit;

  assign lsu_req = '{we: bus.lsu_req_we, sel: bus.lsu_req_sel,
                     addr: bus.lsu_req_addr, wdata: bus.lsu_req_wdata};
  assign dbg_req = '{we: bus.dbg_req_we, sel: bus.dbg_req_sel,
                     addr: bus.dbg_req_addr, wdata: bus.dbg_req_wdata};

  // Grants are gated by rst_n so every RAM-side output is quiet during reset.
  always_comb begin
    lsu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (state == ST_FORCE_DBG) begin
        dbg_gnt = bus.dbg_req_valid;
        lsu_gnt = bus.lsu_req_en & ~bus.dbg_req_valid;
      end else begin
        lsu_gnt = bus.lsu_req_en;
        dbg_gnt = bus.dbg_req_valid & ~bus.lsu_req_en;
      end
    end
  end

  assign any_gnt = lsu_gnt | dbg_gnt;

  always_comb begin
    gnt_req = '0;
    if (dbg_gnt)      gnt_req = dbg_req;
    else if (lsu_gnt) gnt_req = lsu_req;
  end

  assign bus.ram_en        = any_gnt;
  assign bus.ram_we        = byte_we(gnt_req.we, gnt_req.sel);
  assign bus.ram_addr      = gnt_req.addr;
  assign bus.ram_wdata     = gnt_req.wdata;
  assign bus.lsu_stallreq  = rst_n & bus.lsu_req_en & ~lsu_gnt;
  assign bus.dbg_req_ready = dbg_gnt;

  // The counter only runs while debug is actually waiting; reaching the limit
  // hands the next slot to debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ARB;
      burst_cnt <= '0;
    end else begin
      if (!bus.dbg_req_valid || dbg_gnt) begin
        burst_cnt <= '0;
      end else if (lsu_gnt) begin
        if (burst_cnt == BURST_LAST) begin
          burst_cnt <= '0;
          state     <= ST_FORCE_DBG;
        end else begin
          burst_cnt <= burst_cnt + 1'b1;
        end
      end
      if (state == ST_FORCE_DBG && (dbg_gnt || !bus.dbg_req_valid))
        state <= ST_ARB;
    end
  end

  assign tag_in.vld   = any_gnt & ~gnt_req.we;
  assign tag_in.owner = dbg_gnt ? OWN_DBG : OWN_LSU;

  rsp_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_tag (tag_in),
    .out_tag(tag_out)
  );

  assign lsu_hit        = tag_out.vld & (tag_out.owner == OWN_LSU);
  assign dbg_hit        = tag_out.vld & (tag_out.owner == OWN_DBG);
  assign bus.lsu_rvalid = lsu_hit;
  assign bus.dbg_rvalid = dbg_hit;
  assign bus.lsu_rdata  = lsu_hit ? bus.ram_rdata : '0;
  assign bus.dbg_rdata  = dbg_hit ? bus.ram_rdata : '0;

endmodule
